// File: rtl/mem_request_responder.sv
// mem_request_responder: in-order fixed-latency responder for memrequest_* commands with refresh stalls
module mem_request_responder #(
    parameter int ADDR_BITS       = 10,
    parameter int LATENCY         = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int REFRESH_PERIOD  = 512,
    parameter int REFRESH_CYCLES  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [23:0]  memrequest_addr,
    input  logic         memrequest_en,
    input  logic [127:0] memrequest_write_data,
    input  logic         memrequest_write_enable,
    output logic [127:0] memrequest_resp_data,
    output logic         memrequest_complete,
    output logic         memrequest_busy
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int RMAX  = REFRESH_PERIOD > REFRESH_CYCLES ? REFRESH_PERIOD : REFRESH_CYCLES;
    localparam int RW    = $clog2(RMAX + 1);

    typedef enum logic {NORMAL, REFRESH} state_t;

    logic [127:0]         r_mem [DEPTH];
    logic [127:0]         r_dat [LATENCY];
    logic [LATENCY-1:0]   r_vld;
    logic [LATENCY-1:0]   r_rd;
    logic [CW-1:0]        r_out;
    logic [RW-1:0]        r_rcnt;
    state_t               r_state;
    logic                 w_acc;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_unused;

    assign memrequest_busy      = (r_state == REFRESH) || (r_out == CW'(MAX_OUTSTANDING));
    assign w_acc                = memrequest_en && !memrequest_busy;
    assign w_idx                = memrequest_addr[ADDR_BITS-1:0];
    assign w_unused             = ^memrequest_addr[23:ADDR_BITS];
    assign memrequest_complete  = r_vld[LATENCY-1];
    assign memrequest_resp_data = (r_vld[LATENCY-1] && r_rd[LATENCY-1]) ? r_dat[LATENCY-1] : '0;

    // Backing array: written on an accepted write; upper address bits alias
    always_ff @(posedge clk) begin
        if (!rst && w_acc && memrequest_write_enable)
            r_mem[w_idx] <= memrequest_write_data;
    end

    // Latency pipe control bits: cleared by reset so in-flight commands vanish
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_rd  <= '0;
        end else begin
            r_vld[0] <= w_acc;
            r_rd[0]  <= w_acc && !memrequest_write_enable;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_rd[i]  <= r_rd[i-1];
            end
        end
    end

    // Latency pipe data: word captured at the accept edge, masked at the output unless a valid read
    always_ff @(posedge clk) begin
        r_dat[0] <= r_mem[w_idx];
        for (int i = 1; i < LATENCY; i++)
            r_dat[i] <= r_dat[i-1];
    end

    // Outstanding count: accept and complete on the same edge cancel
    always_ff @(posedge clk) begin
        if (rst)
            r_out <= '0;
        else
            r_out <= r_out + CW'(w_acc) - CW'(memrequest_complete);
    end

    // Refresh FSM: periodic busy window; disabled entirely when the period is zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= NORMAL;
            r_rcnt  <= '0;
        end else if (r_state == NORMAL) begin
            if (REFRESH_PERIOD != 0) begin
                if (r_rcnt == RW'(REFRESH_PERIOD - 1)) begin
                    r_state <= REFRESH;
                    r_rcnt  <= '0;
                end else begin
                    r_rcnt <= r_rcnt + RW'(1);
                end
            end
        end else if (r_rcnt == RW'(REFRESH_CYCLES - 1)) begin
            r_state <= NORMAL;
            r_rcnt  <= '0;
        end else begin
            r_rcnt <= r_rcnt + RW'(1);
        end
    end
endmodule

// File: tb/tb_mem_request_responder.sv
// tb_mem_request_responder: directed checks of latency, aliasing, backpressure, refresh and reset
module tb_mem_request_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [23:0]  addr_a = '0, addr_b = '0, addr_c = '0;
    logic         en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic         we_a = 1'b0, we_b = 1'b0, we_c = 1'b0;
    logic [127:0] wd_a = '0, wd_b = '0, wd_c = '0;
    logic [127:0] rd_a, rd_b, rd_c;
    logic         cp_a, cp_b, cp_c;
    logic         bz_a, bz_b, bz_c;
    int           n_chk = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    mem_request_responder #(.ADDR_BITS(10), .LATENCY(4), .MAX_OUTSTANDING(8), .REFRESH_PERIOD(0), .REFRESH_CYCLES(16)) u_a (
        .clk(clk), .rst(rst), .memrequest_addr(addr_a), .memrequest_en(en_a),
        .memrequest_write_data(wd_a), .memrequest_write_enable(we_a),
        .memrequest_resp_data(rd_a), .memrequest_complete(cp_a), .memrequest_busy(bz_a));

    mem_request_responder #(.ADDR_BITS(10), .LATENCY(12), .MAX_OUTSTANDING(8), .REFRESH_PERIOD(0), .REFRESH_CYCLES(16)) u_b (
        .clk(clk), .rst(rst), .memrequest_addr(addr_b), .memrequest_en(en_b),
        .memrequest_write_data(wd_b), .memrequest_write_enable(we_b),
        .memrequest_resp_data(rd_b), .memrequest_complete(cp_b), .memrequest_busy(bz_b));

    mem_request_responder #(.ADDR_BITS(10), .LATENCY(4), .MAX_OUTSTANDING(8), .REFRESH_PERIOD(32), .REFRESH_CYCLES(4)) u_c (
        .clk(clk), .rst(rst), .memrequest_addr(addr_c), .memrequest_en(en_c),
        .memrequest_write_data(wd_c), .memrequest_write_enable(we_c),
        .memrequest_resp_data(rd_c), .memrequest_complete(cp_c), .memrequest_busy(bz_c));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_all;
        rst = 1'b1;
        step;
        step;
        rst = 1'b0;
    endtask

    // write then read on the next edge, checking both completions on u_a
    task automatic wr_rd(input string tag, input logic [23:0] wa, input logic [127:0] d, input logic [23:0] ra);
        chk({tag, "_busy"}, {127'd0, bz_a}, 128'd0);
        en_a = 1'b1; we_a = 1'b1; addr_a = wa; wd_a = d;
        step;
        we_a = 1'b0; addr_a = ra;
        step;
        en_a = 1'b0;
        step;
        chk({tag, "_early"}, {127'd0, cp_a}, 128'd0);
        step;
        chk({tag, "_wr_cp"}, {127'd0, cp_a}, 128'd1);
        chk({tag, "_wr_data"}, rd_a, 128'd0);
        step;
        chk({tag, "_rd_cp"}, {127'd0, cp_a}, 128'd1);
        chk({tag, "_rd_data"}, rd_a, d);
        step;
        chk({tag, "_after"}, {127'd0, cp_a}, 128'd0);
    endtask

    function automatic bit acc3(input int k);
        return (k >= 1 && k <= 8) || (k >= 14 && k <= 21) || (k >= 27 && k <= 30);
    endfunction

    function automatic bit cmp3(input int k);
        return (k >= 12 && k <= 19) || (k >= 25 && k <= 32) || (k >= 38 && k <= 41);
    endfunction

    initial begin
        int idx, cidx, ncp, budget;
        bit acc, e_cp;
        // reset values
        reset_all;
        chk("rst_cp_a", {127'd0, cp_a}, 128'd0);
        chk("rst_bz_a", {127'd0, bz_a}, 128'd0);
        chk("rst_rd_a", rd_a, 128'd0);
        chk("rst_cp_b", {127'd0, cp_b}, 128'd0);
        chk("rst_bz_b", {127'd0, bz_b}, 128'd0);
        chk("rst_cp_c", {127'd0, cp_c}, 128'd0);
        chk("rst_bz_c", {127'd0, bz_c}, 128'd0);
        // preload u_c addr 0 and u_b addr 0..19
        en_c = 1'b1; we_c = 1'b1; addr_c = 24'd0; wd_c = 128'h77;
        step;
        en_c = 1'b0; we_c = 1'b0;
        for (int i = 0; i < 20; i++) begin
            en_b = 1'b1; we_b = 1'b1; addr_b = 24'(i); wd_b = 128'(100 + i);
            budget = 0;
            do begin
                acc = !bz_b;
                step;
                budget++;
            end while (!acc && budget < 50);
            if (!acc) chk("pre_b_timeout", 128'd0, 128'd1);
        end
        en_b = 1'b0; we_b = 1'b0;
        repeat (20) step;
        // write/read same address, then alias
        wr_rd("t1", 24'd5, {16{8'hA5}}, 24'd5);
        wr_rd("t2", 24'h000400, 128'h1, 24'd0);
        // reset with three reads in flight
        en_a = 1'b1; we_a = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            addr_a = 24'(i); wd_a = 128'(1000 + i);
            step;
        end
        en_a = 1'b0; we_a = 1'b0;
        repeat (6) step;
        en_a = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            addr_a = 24'(i);
            step;
        end
        en_a = 1'b0; rst = 1'b1;
        step;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) chk("t6_no_cp", {127'd0, cp_a}, 128'd0);
        for (int i = 0; i < 8; i++) begin
            step;
            chk("t6_no_cp_run", {127'd0, cp_a}, 128'd0);
        end
        en_a = 1'b1; addr_a = 24'd8;
        step;
        en_a = 1'b0;
        step;
        step;
        step;
        chk("t6_rd_cp", {127'd0, cp_a}, 128'd1);
        chk("t6_rd_data", rd_a, 128'd1008);
        // backpressure at MAX_OUTSTANDING with LATENCY 12
        reset_all;
        idx = 0; cidx = 0; ncp = 0;
        for (int k = 1; k <= 45; k++) begin
            en_b = (k <= 30); we_b = 1'b0; addr_b = 24'(idx);
            if (k <= 30) chk($sformatf("t3_busy_%0d", k), {127'd0, bz_b}, {127'd0, !acc3(k)});
            step;
            if (acc3(k)) idx++;
            e_cp = cmp3(k);
            chk($sformatf("t3_cp_%0d", k), {127'd0, cp_b}, {127'd0, e_cp});
            chk($sformatf("t3_data_%0d", k), rd_b, e_cp ? 128'(100 + cidx) : 128'd0);
            if (e_cp) cidx++;
            if (cp_b) ncp++;
        end
        en_b = 1'b0;
        chk("t3_total_cp", 128'(ncp), 128'd20);
        // refresh window on u_c
        reset_all;
        en_c = 1'b1; we_c = 1'b0; addr_c = 24'd0;
        for (int c = 0; c <= 45; c++) begin
            e_cp = (c >= 4 && c <= 35) || c >= 40;
            chk($sformatf("t4_busy_%0d", c), {127'd0, bz_c}, {127'd0, (c >= 32 && c <= 35)});
            chk($sformatf("t4_cp_%0d", c), {127'd0, cp_c}, {127'd0, e_cp});
            chk($sformatf("t4_data_%0d", c), rd_c, e_cp ? 128'h77 : 128'd0);
            step;
        end
        en_c = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
